rs_pool: RTL and testbench
==========================

// Module: rs_pool
// PURPOSE
//  Parametrised reservation station, successor to the fixed rs_alu/rs_ls stations. Holds DEPTH
//  dispatched ops, snoops NUM_CDB result buses for operand tags, and issues the oldest ready
//  entry through a registered valid/ready port to one execute unit. Sits between allocator
//  and ex_alu/ex_ls; adds flush, backpressure, occupancy count and same-cycle CDB forwarding.
// PARAMETERS
//  DEPTH    8   number of entries (power of 2, >=2)
//  NUM_CDB  3   number of result broadcast buses snooped
//  TAG_W    4   regtag width; tag 0 = operand value present
//  OP_W     6   sinst_t op-code width
//  DATA_W   32  operand width
//  RADDR_W  5   destination register address width
//  PC_W     32  pc width
// PORTS
//  clk        in   1                  clock; all state updates on rising edge
//  rst        in   1                  synchronous reset, active high
//  rdy        in   1                  low: hold all state, outputs stable
//  flush      in   1                  discard all entries and pending output
//  in_en      in   1                  allocate request
//  in_op      in   OP_W               op
//  in_pc      in   PC_W               instruction pc
//  in_tagx    in   TAG_W              producer tag of operand x (0 = ready)
//  in_tagy    in   TAG_W              producer tag of operand y
//  in_tagw    in   TAG_W              tag this op will broadcast
//  in_datax   in   DATA_W             operand x value (valid when tag 0)
//  in_datay   in   DATA_W             operand y value
//  in_addrw   in   RADDR_W            destination register
//  full       out  1                  no free entry; in_en ignored
//  count      out  $clog2(DEPTH)+1    occupied entries (excl. output register)
//  cdb_en     in   NUM_CDB            per-bus broadcast valid
//  cdb_tag    in   NUM_CDB*TAG_W      bus k tag at [k*TAG_W +: TAG_W]
//  cdb_data   in   NUM_CDB*DATA_W     bus k data at [k*DATA_W +: DATA_W]
//  out_valid  out  1                  issue slot holds ready op
//  out_ready  in   1                  execute unit accepts
//  out_op/out_pc/out_datax/out_datay/out_tagw/out_addrw  out  as inputs   issued op
// BEHAVIOUR
//  - Reset (rst=1 at edge): all entries invalid, age matrix cleared, out_valid=0, out_* = 0,
//    count=0, full=0. rst overrides rdy, flush and in_en.
//  - rdy=0: no state changes; CDB broadcasts in that cycle are lost (producers also stalled).
//  - flush=1 (rdy=1): next edge all entries invalid, count=0, out_valid=0; in_en ignored.
//  - Accept: in_en && !full; write lowest-index free entry; entry marked younger than all valid.
//  - full = (count==DEPTH), registered; insert never accepted when full even if an issue frees
//    a slot that cycle. count next = count + accept - issue_to_output.
//  - Forwarding at insert: if cdb_en[k] && cdb_tag[k]==in_tagx (nonzero), store cdb_data[k],
//    tag 0; same for y. Wakeup: each edge, every valid entry with nonzero tag matching an
//    enabled bus captures data, tag 0. Multiple matching buses: lowest k wins. cdb_tag 0 ignored.
//  - Ready entry: valid && tagx==0 && tagy==0, evaluated on registered state (entry woken at
//    edge N selectable in cycle after N).
//  - Select: oldest ready entry via DEPTHxDEPTH age matrix. Output register loads when
//    !out_valid || out_ready; loaded entry freed same edge. Output register needs no snooping.
//  - Handshake: transfer when out_valid && out_ready; out_* stable while out_valid && !out_ready.
//  - Latency: op accepted ready at edge N -> out_valid high after edge N+1 (1 cycle in pool).
//  - Throughput: one issue per cycle; one accept per cycle.
// TESTING
//  1. rst; in_en, tags 0, datax=5, datay=7, out_ready=1 -> out_valid next cycle, datax=5,
//     datay=7, count back to 0.
//  2. insert tagx=3; two cycles later cdb_en[1], tag 3, data 0xDEAD -> out_datax=0xDEAD,
//     out_valid asserted one cycle after the broadcast edge.
//  3. insert tagy=2 while cdb0 tag 2 data 0x11 same cycle -> entry ready, out_datay=0x11
//     after the next edge.
//  4. out_ready=0, fill output reg, then 8 inserts on tagx=5 -> full=1, count=8; 9th in_en
//     dropped; broadcast tag 5 -> entries issue oldest-first as out_ready pulses.
//  5. insert A(tagx=4), B ready, C ready, then wake tag 4 -> issue order B, C, A.
//  6. 5 entries + out_valid=1, pulse flush -> count=0, out_valid=0; with rdy=0 during
//     inserts/broadcasts -> no change in count, out_* or entry state.

Source files
------------

// File: rtl/rs_pool.sv
// rs_pool: parametrised reservation station.
// Holds DEPTH dispatched ops, snoops NUM_CDB result buses for operand tags and
// issues the oldest ready entry through a registered valid/ready output port.
// Ports:
//   clk, rst (sync, active high), rdy (global stall), flush (discard all)
//   in_*      : allocate request and op payload; full/count report occupancy
//   cdb_*     : NUM_CDB packed result buses (bus k at slice k)
//   out_*     : issued op, out_valid/out_ready handshake
module rs_pool #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      in_en,
    input  logic [OP_W-1:0]           in_op,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [TAG_W-1:0]          in_tagx,
    input  logic [TAG_W-1:0]          in_tagy,
    input  logic [TAG_W-1:0]          in_tagw,
    input  logic [DATA_W-1:0]         in_datax,
    input  logic [DATA_W-1:0]         in_datay,
    input  logic [RADDR_W-1:0]        in_addrw,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    input  logic [NUM_CDB-1:0]        cdb_en,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_op,
    output logic [PC_W-1:0]           out_pc,
    output logic [DATA_W-1:0]         out_datax,
    output logic [DATA_W-1:0]         out_datay,
    output logic [TAG_W-1:0]          out_tagw,
    output logic [RADDR_W-1:0]        out_addrw
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Returns {tag, data} after snooping the buses; lowest-numbered matching bus wins.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         data,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] datas
    );
        snoop = {tag, data};
        if (tag != '0) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (en[k] && tags[k*TAG_W +: TAG_W] == tag)
                    snoop = {{TAG_W{1'b0}}, datas[k*DATA_W +: DATA_W]};
            end
        end
    endfunction

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   age_q [DEPTH];   // age_q[i][j]: entry i older than entry j
    logic [DEPTH-1:0]   age_d [DEPTH];
    logic [TAG_W-1:0]   tagx_q [DEPTH], tagx_d [DEPTH];
    logic [TAG_W-1:0]   tagy_q [DEPTH], tagy_d [DEPTH];
    logic [DATA_W-1:0]  datax_q [DEPTH], datax_d [DEPTH];
    logic [DATA_W-1:0]  datay_q [DEPTH], datay_d [DEPTH];
    logic [OP_W-1:0]    op_q [DEPTH], op_d [DEPTH];
    logic [PC_W-1:0]    pc_q [DEPTH], pc_d [DEPTH];
    logic [TAG_W-1:0]   tagw_q [DEPTH], tagw_d [DEPTH];
    logic [RADDR_W-1:0] addrw_q [DEPTH], addrw_d [DEPTH];

    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               out_valid_q, out_valid_d;
    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic [DATA_W-1:0]  out_datax_q, out_datax_d;
    logic [DATA_W-1:0]  out_datay_q, out_datay_d;
    logic [TAG_W-1:0]   out_tagw_q, out_tagw_d;
    logic [RADDR_W-1:0] out_addrw_q, out_addrw_d;

    logic [DEPTH-1:0]   ready;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    logic               any_ready, blocked, load, issue, accept;

    always_comb begin
        valid_d     = valid_q;
        age_d       = age_q;
        tagx_d      = tagx_q;
        tagy_d      = tagy_q;
        datax_d     = datax_q;
        datay_d     = datay_q;
        op_d        = op_q;
        pc_d        = pc_q;
        tagw_d      = tagw_q;
        addrw_d     = addrw_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_pc_d    = out_pc_q;
        out_datax_d = out_datax_q;
        out_datay_d = out_datay_q;
        out_tagw_d  = out_tagw_q;
        out_addrw_d = out_addrw_q;
        sel_idx     = '0;
        free_idx    = '0;
        any_ready   = 1'b0;
        blocked     = 1'b0;

        // Readiness is taken from registered state only.
        for (int i = 0; i < DEPTH; i++)
            ready[i] = valid_q[i] && tagx_q[i] == '0 && tagy_q[i] == '0;

        // Oldest ready entry: no other ready entry is older than it.
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (ready[j] && age_q[j][i]) blocked = 1'b1;
            if (ready[i] && !blocked) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end

        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = IDX_W'(i);

        load   = !out_valid_q || out_ready;
        issue  = load && any_ready;
        accept = in_en && !full_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                {tagx_d[i], datax_d[i]} = snoop(tagx_q[i], datax_q[i], cdb_en, cdb_tag, cdb_data);
                {tagy_d[i], datay_d[i]} = snoop(tagy_q[i], datay_q[i], cdb_en, cdb_tag, cdb_data);
            end
        end

        if (load) out_valid_d = any_ready;
        if (issue) begin
            valid_d[sel_idx] = 1'b0;
            out_op_d         = op_q[sel_idx];
            out_pc_d         = pc_q[sel_idx];
            out_datax_d      = datax_q[sel_idx];
            out_datay_d      = datay_q[sel_idx];
            out_tagw_d       = tagw_q[sel_idx];
            out_addrw_d      = addrw_q[sel_idx];
        end

        if (accept) begin
            valid_d[free_idx] = 1'b1;
            {tagx_d[free_idx], datax_d[free_idx]} = snoop(in_tagx, in_datax, cdb_en, cdb_tag, cdb_data);
            {tagy_d[free_idx], datay_d[free_idx]} = snoop(in_tagy, in_datay, cdb_en, cdb_tag, cdb_data);
            op_d[free_idx]    = in_op;
            pc_d[free_idx]    = in_pc;
            tagw_d[free_idx]  = in_tagw;
            addrw_d[free_idx] = in_addrw;
            // New entry is younger than every entry currently held.
            age_d[free_idx] = '0;
            for (int i = 0; i < DEPTH; i++)
                age_d[i][free_idx] = valid_q[i];
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(issue);

        if (flush) begin
            valid_d     = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end

        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Control state and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            age_q       <= '{default: '0};
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_pc_q    <= '0;
            out_datax_q <= '0;
            out_datay_q <= '0;
            out_tagw_q  <= '0;
            out_addrw_q <= '0;
        end else if (rdy) begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_pc_q    <= out_pc_d;
            out_datax_q <= out_datax_d;
            out_datay_q <= out_datay_d;
            out_tagw_q  <= out_tagw_d;
            out_addrw_q <= out_addrw_d;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (rdy) begin
            tagx_q  <= tagx_d;
            tagy_q  <= tagy_d;
            datax_q <= datax_d;
            datay_q <= datay_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            tagw_q  <= tagw_d;
            addrw_q <= addrw_d;
        end
    end

    assign full      = full_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_pc    = out_pc_q;
    assign out_datax = out_datax_q;
    assign out_datay = out_datay_q;
    assign out_tagw  = out_tagw_q;
    assign out_addrw = out_addrw_q;
endmodule

// File: tb/tb_rs_pool.sv
// tb_rs_pool: self-checking bench for rs_pool (default parameters).
module tb_rs_pool;
    localparam int DEPTH = 8;
    localparam int NUM_CDB = 3;
    localparam int TAG_W = 4;
    localparam int OP_W = 6;
    localparam int DATA_W = 32;
    localparam int RADDR_W = 5;
    localparam int PC_W = 32;

    logic                      clk = 1'b0;
    logic                      rst, rdy, flush, in_en, out_ready;
    logic [OP_W-1:0]           in_op;
    logic [PC_W-1:0]           in_pc;
    logic [TAG_W-1:0]          in_tagx, in_tagy, in_tagw;
    logic [DATA_W-1:0]         in_datax, in_datay;
    logic [RADDR_W-1:0]        in_addrw;
    logic                      full, out_valid;
    logic [3:0]                count;
    logic [NUM_CDB-1:0]        cdb_en;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic [OP_W-1:0]           out_op;
    logic [PC_W-1:0]           out_pc;
    logic [DATA_W-1:0]         out_datax, out_datay;
    logic [TAG_W-1:0]          out_tagw;
    logic [RADDR_W-1:0]        out_addrw;

    int n_cmp = 0;
    int n_bad = 0;

    rs_pool #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .OP_W(OP_W),
              .DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_en(in_en),
        .in_op(in_op), .in_pc(in_pc), .in_tagx(in_tagx), .in_tagy(in_tagy),
        .in_tagw(in_tagw), .in_datax(in_datax), .in_datay(in_datay),
        .in_addrw(in_addrw), .full(full), .count(count), .cdb_en(cdb_en),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
        .out_datax(out_datax), .out_datay(out_datay), .out_tagw(out_tagw),
        .out_addrw(out_addrw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  tx, ty;
        logic [31:0] dx, dy;
        logic [2:0]  cen;
        logic [11:0] ctag;
        logic [95:0] cdat;
        logic        ov;
        logic [31:0] odx, ody;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [3:0]  tx, ty, tw;
        logic [31:0] dx, dy;
        logic [4:0]  aw;
    } ent_t;

    ent_t pool[$];
    ent_t m_out;
    bit   m_ov;
    vec_t tbl[19];

    function automatic vec_t mk(input logic en, input logic [3:0] tx, input logic [3:0] ty,
                                input logic [31:0] dx, input logic [31:0] dy,
                                input logic [2:0] cen, input logic [11:0] ctag,
                                input logic [95:0] cdat, input logic ov,
                                input logic [31:0] odx, input logic [31:0] ody,
                                input logic [3:0] cnt);
        vec_t v;
        v.en = en; v.tx = tx; v.ty = ty; v.dx = dx; v.dy = dy;
        v.cen = cen; v.ctag = ctag; v.cdat = cdat;
        v.ov = ov; v.odx = odx; v.ody = ody; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_en = 1'b0;
        in_op = '0; in_pc = '0; in_tagx = '0; in_tagy = '0; in_tagw = '0;
        in_datax = '0; in_datay = '0; in_addrw = '0;
        cdb_en = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic ins(input logic [3:0] tx, input logic [31:0] dx, input logic [31:0] dy);
        in_en = 1'b1; in_tagx = tx; in_tagy = '0; in_datax = dx; in_datay = dy;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1; in_en = 1'b1; in_datax = 32'h1234; flush = 1'b0;
        step(); step();
        idle();
    endtask

    // Reference: capture from the lowest enabled bus carrying the operand's tag.
    function automatic ent_t wake(input ent_t e);
        ent_t r;
        bit   gx, gy;
        r = e; gx = 1'b0; gy = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!gx && r.tx != 0 && cdb_en[k] && cdb_tag[k*4 +: 4] == r.tx) begin
                r.dx = cdb_data[k*32 +: 32]; r.tx = 0; gx = 1'b1;
            end
            if (!gy && r.ty != 0 && cdb_en[k] && cdb_tag[k*4 +: 4] == r.ty) begin
                r.dy = cdb_data[k*32 +: 32]; r.ty = 0; gy = 1'b1;
            end
        end
        return r;
    endfunction

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_edge();
        ent_t ne;
        int   f;
        bit   was_full;
        if (!rdy) return;
        if (flush) begin
            pool.delete();
            m_ov = 1'b0;
            return;
        end
        was_full = (pool.size() == DEPTH);
        if (!m_ov || out_ready) begin
            f = -1;
            for (int i = 0; i < pool.size(); i++)
                if (f < 0 && pool[i].tx == 0 && pool[i].ty == 0) f = i;
            if (f >= 0) begin
                m_out = pool[f];
                pool.delete(f);
                m_ov = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < pool.size(); i++) pool[i] = wake(pool[i]);
        if (in_en && !was_full) begin
            ne.op = in_op; ne.pc = in_pc; ne.tx = in_tagx; ne.ty = in_tagy; ne.tw = in_tagw;
            ne.dx = in_datax; ne.dy = in_datay; ne.aw = in_addrw;
            pool.push_back(wake(ne));
        end
    endtask

    logic [31:0] seen[$];

    initial begin
        tbl[0]  = mk(1, 0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 3, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 3'b010, 12'h030, {32'h0, 32'hDEAD, 32'h0}, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 9, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 2, 1, 0, 3'b001, 12'h002, {64'h0, 32'h11}, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 3, 3'b111, 12'h111, {32'hA2, 32'hA1, 32'hA0}, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0, 3, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 2, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 3'b110, 12'h220, {32'hB2, 32'hB1, 32'h0}, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB1, 4, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        out_ready = 1'b1;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_out_datax", 64'(out_datax), 0);
        chk("rst_out_op", 64'(out_op), 0);

        // Single-cycle vectors: issue latency, wakeup, insert forwarding, bus priority
        for (int i = 0; i < 19; i++) begin
            in_en = tbl[i].en; in_tagx = tbl[i].tx; in_tagy = tbl[i].ty;
            in_datax = tbl[i].dx; in_datay = tbl[i].dy;
            cdb_en = tbl[i].cen; cdb_tag = tbl[i].ctag; cdb_data = tbl[i].cdat;
            step();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_datax", i), 64'(out_datax), 64'(tbl[i].odx));
                chk($sformatf("vec%0d_datay", i), 64'(out_datay), 64'(tbl[i].ody));
            end
        end

        // Fill to full under backpressure, then drain oldest-first
        idle(); out_ready = 1'b0;
        ins(0, 32'h100, 32'h100); step();
        idle(); step();
        chk("fill_out_valid", 64'(out_valid), 1);
        for (int i = 0; i < 8; i++) begin
            ins(5, 0, i); step();
        end
        chk("fill_count", 64'(count), 8);
        chk("fill_full", 64'(full), 1);
        ins(0, 32'h99, 32'h99); step();
        chk("ninth_dropped_count", 64'(count), 8);
        chk("ninth_full", 64'(full), 1);
        idle(); cdb_en = 3'b100; cdb_tag = 12'h500; cdb_data = {32'h55, 64'h0}; step();
        idle();
        chk("stall_hold_datay", 64'(out_datay), 64'h100);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("drain%0d_valid", k), 64'(out_valid), 1);
            chk($sformatf("drain%0d_datay", k), 64'(out_datay), 64'(k));
            chk($sformatf("drain%0d_datax", k), 64'(out_datax), 64'h55);
            chk($sformatf("drain%0d_count", k), 64'(count), 64'(7 - k));
        end
        step();
        chk("drain_empty_valid", 64'(out_valid), 0);

        // A waits on tag 4 while younger B, C issue first
        idle(); out_ready = 1'b1; seen.delete();
        ins(4, 0, 32'hA); step();
        ins(0, 0, 32'hB); step();
        ins(0, 0, 32'hC); step();
        if (out_valid) seen.push_back(out_datay);
        idle(); cdb_en = 3'b001; cdb_tag = 12'h004; cdb_data = {64'h0, 32'h44}; step();
        if (out_valid) seen.push_back(out_datay);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen.push_back(out_datay);
        end
        chk("bca_issue_count", 64'(seen.size()), 3);
        if (seen.size() == 3) begin
            chk("bca_first", 64'(seen[0]), 64'hB);
            chk("bca_second", 64'(seen[1]), 64'hC);
            chk("bca_third", 64'(seen[2]), 64'hA);
        end

        // Age order: once all are ready, the oldest (A) goes first
        idle(); out_ready = 1'b0;
        ins(0, 0, 32'hF0); step();
        ins(4, 0, 32'hA); step();
        ins(0, 0, 32'hB); step();
        ins(0, 0, 32'hC); step();
        idle(); cdb_en = 3'b001; cdb_tag = 12'h004; cdb_data = {64'h0, 32'h44}; step();
        idle(); out_ready = 1'b1;
        step(); chk("age_first", 64'(out_datay), 64'hA); chk("age_first_x", 64'(out_datax), 64'h44);
        step(); chk("age_second", 64'(out_datay), 64'hB);
        step(); chk("age_third", 64'(out_datay), 64'hC);
        step(); chk("age_done_valid", 64'(out_valid), 0);

        // Stall with rdy=0, then flush
        idle(); out_ready = 1'b0;
        ins(0, 0, 32'h60); step();
        for (int i = 0; i < 5; i++) begin
            ins(6, 0, i); step();
        end
        chk("pre_stall_count", 64'(count), 5);
        chk("pre_stall_valid", 64'(out_valid), 1);
        rdy = 1'b0; ins(0, 0, 32'h77); out_ready = 1'b1;
        cdb_en = 3'b001; cdb_tag = 12'h006; cdb_data = {64'h0, 32'h66};
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d_count", i), 64'(count), 5);
            chk($sformatf("stall%0d_valid", i), 64'(out_valid), 1);
            chk($sformatf("stall%0d_datay", i), 64'(out_datay), 64'h60);
        end
        idle(); out_ready = 1'b1; step();
        chk("lost_bcast_valid", 64'(out_valid), 0);
        chk("lost_bcast_count", 64'(count), 5);
        out_ready = 1'b0;
        ins(0, 0, 32'h61); step();
        idle(); step();
        chk("pre_flush_valid", 64'(out_valid), 1);
        chk("pre_flush_count", 64'(count), 5);
        flush = 1'b1; ins(0, 0, 32'h62); step();
        idle();
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_full", 64'(full), 0);
        cdb_en = 3'b001; cdb_tag = 12'h006; cdb_data = {64'h0, 32'h66}; step();
        idle(); step(); step();
        chk("post_flush_valid", 64'(out_valid), 0);
        chk("post_flush_count", 64'(count), 0);

        // Randomised traffic against the queue model
        do_reset();
        pool.delete(); m_ov = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 79) == 0);
            in_en     = ($urandom_range(0, 3) != 0);
            out_ready = ((cyc / 150) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 3) != 0);
            in_op     = 6'($urandom());
            in_pc     = $urandom();
            in_tagx   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
            in_tagy   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
            in_tagw   = 4'($urandom());
            in_datax  = $urandom();
            in_datay  = $urandom();
            in_addrw  = 5'($urandom());
            cdb_en    = 3'($urandom());
            for (int k = 0; k < NUM_CDB; k++) cdb_tag[k*4 +: 4] = 4'($urandom_range(0, 3));
            cdb_data  = {$urandom(), $urandom(), $urandom()};
            model_edge();
            step();
            chk("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            chk("rnd_count", 64'(count), 64'(pool.size()));
            chk("rnd_full", 64'(full), 64'(pool.size() == DEPTH));
            if (m_ov) begin
                chk("rnd_op", 64'(out_op), 64'(m_out.op));
                chk("rnd_pc", 64'(out_pc), 64'(m_out.pc));
                chk("rnd_datax", 64'(out_datax), 64'(m_out.dx));
                chk("rnd_datay", 64'(out_datay), 64'(m_out.dy));
                chk("rnd_tagw", 64'(out_tagw), 64'(m_out.tw));
                chk("rnd_addrw", 64'(out_addrw), 64'(m_out.aw));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
